icache_storage_sa: RTL and testbench

Parametrised N-way set-associative instruction-cache storage with multi-word lines, tree pseudo-LRU replacement, a line-fill state machine and a whole-cache flush sequencer. It sits between the icache controller and its refill path. Lookups return a registered hit, data and way one cycle after issue. Refill beats stream in word by word and make the line valid only after the final beat. Addresses are word addresses: {tag, index, offset}.

---
 rtl/icache_sa_pkg.sv | 59 +++++
 rtl/icache_storage_sa_plru.sv | 50 +++++
 rtl/icache_storage_sa.sv | 204 ++++++++++++++++++++
 tb/tb_icache_storage_sa.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_sa_pkg.sv
// Shared types and PLRU tree helpers for the
// set-associative icache storage.
package icache_sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH
  } state_e;

  localparam int TAG_WIDTH  = 25;
  localparam int WAY_W      = 1;
  localparam int LINE_WORDS = 4;

  localparam int PLRU_MAX = 7;
  localparam int WAY_MAX  = 3;

  typedef logic [PLRU_MAX-1:0] plru_t;
  typedef logic [WAY_MAX-1:0]  wayx_t;

  // Node bit 0 steers the victim to the lower half.
  function automatic wayx_t plru_victim(
    plru_t bits,
    int    levels
  );
    int    node;
    wayx_t way;
    node = 0;
    way  = '0;
    for (int l = 0; l < WAY_MAX; l++) begin
      if (l < levels) begin
        way  = {way[WAY_MAX-2:0], bits[node]};
        node = 2 * node + 1 + int'(bits[node]);
      end
    end
    return way;
  endfunction

  function automatic plru_t plru_update(
    plru_t bits,
    wayx_t way,
    int    levels
  );
    plru_t r;
    int    node;
    logic  b;
    r    = bits;
    node = 0;
    for (int l = 0; l < WAY_MAX; l++) begin
      if (l < levels) begin
        b       = way[levels-1-l];
        r[node] = ~b;
        node    = 2 * node + 1 + int'(b);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icache_storage_sa_plru.sv
// Per-set tree pseudo-LRU state with read,
// two touch ports and a per-set clear.
module icache_plru
  import icache_sa_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int INDEX_WIDTH = 5,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [WW-1:0]          rd_victim,
  input  logic                   hit_en,
  input  logic [INDEX_WIDTH-1:0] hit_index,
  input  logic [WW-1:0]          hit_way,
  input  logic                   fill_en,
  input  logic [INDEX_WIDTH-1:0] fill_index,
  input  logic [WW-1:0]          fill_way,
  input  logic                   clr_en,
  input  logic [INDEX_WIDTH-1:0] clr_index
);

  localparam int SETS = 1 << INDEX_WIDTH;
  localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int LV   = $clog2(WAYS);

  logic [PW-1:0] bits_q [SETS];

  assign rd_victim = WW'(plru_victim(
    plru_t'(bits_q[rd_index]), LV));

  // Fill touch is applied last so it wins on a shared set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else begin
      if (clr_en) bits_q[clr_index] <= '0;
      if (hit_en)
        bits_q[hit_index] <= PW'(plru_update(
          plru_t'(bits_q[hit_index]),
          wayx_t'(hit_way), LV));
      if (fill_en)
        bits_q[fill_index] <= PW'(plru_update(
          plru_t'(bits_q[fill_index]),
          wayx_t'(fill_way), LV));
    end
  end

endmodule

// File: rtl/icache_storage_sa.sv
// N-way set-associative icache storage with
// line fill and whole-cache flush sequencing.
module icache_storage_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 5,
  parameter int OFFSET_WIDTH = 2,
  parameter int WAYS         = 2,
  parameter int TAG_WIDTH    =
    ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_ready,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [WB-1:0]         rsp_way,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  fill_ready,
  input  logic                  fill_beat_valid,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_done,
  input  logic                  flush_req,
  output logic                  busy
);

  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;

  state_e state_q, state_d;

  logic [INDEX_WIDTH-1:0]  set_cnt_q;
  logic [INDEX_WIDTH-1:0]  fill_idx_q;
  logic [TAG_WIDTH-1:0]    fill_tag_q;
  logic [WB-1:0]           victim_q;
  logic [OFFSET_WIDTH-1:0] beat_cnt_q;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][WORDS];

  logic [TAG_WIDTH-1:0]    l_tag;
  logic [INDEX_WIDTH-1:0]  l_idx;
  logic [OFFSET_WIDTH-1:0] l_off;
  logic [TAG_WIDTH-1:0]    f_tag;
  logic [INDEX_WIDTH-1:0]  f_idx;
  logic                    unused_fill_off;

  logic            accept;
  logic            fill_go;
  logic            flush_go;
  logic            beat_en;
  logic            last_beat;
  logic            flushing;
  logic            any_hit;
  logic [WAYS-1:0] hit_vec;
  logic [WB-1:0]   hit_way;
  logic [WB-1:0]   plru_vic;
  logic [WB-1:0]   victim_sel;

  assign l_tag = lookup_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign l_idx = lookup_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign l_off = lookup_addr[OFFSET_WIDTH-1:0];
  assign f_tag = fill_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign f_idx = fill_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unused_fill_off = ^fill_addr[OFFSET_WIDTH-1:0];

  assign lookup_ready = (state_q != ST_FLUSH);
  assign fill_ready   = (state_q == ST_IDLE) && !flush_req;
  assign busy         = (state_q != ST_IDLE);

  assign accept    = lookup_valid && lookup_ready;
  assign fill_go   = fill_start && fill_ready;
  assign flush_go  = (state_q == ST_IDLE) && flush_req;
  assign beat_en   = (state_q == ST_FILL) && fill_beat_valid;
  assign last_beat = beat_en && (beat_cnt_q == '1);
  assign flushing  = (state_q == ST_FLUSH);
  assign any_hit   = |hit_vec;

  // The line under refill never hits, even if its tag matches.
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[l_idx][w] &&
                   (tag_q[l_idx][w] == l_tag);
      if ((state_q == ST_FILL) &&
          (fill_idx_q == l_idx) &&
          (victim_q == WB'(w)))
        hit_vec[w] = 1'b0;
    end
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WB'(w);
  end

  always_comb begin
    victim_sel = plru_vic;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[f_idx][w]) victim_sel = WB'(w);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_go)     state_d = ST_FLUSH;
        else if (fill_go) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (last_beat) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (set_cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      set_cnt_q  <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      victim_q   <= '0;
      fill_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_done <= last_beat;
      if (fill_go) begin
        fill_idx_q <= f_idx;
        fill_tag_q <= f_tag;
        victim_q   <= victim_sel;
        beat_cnt_q <= '0;
      end else if (beat_en) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (flushing) set_cnt_q <= set_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_data  <= '0;
      rsp_way   <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_hit   <= accept && any_hit;
      rsp_way   <= (accept && any_hit) ? hit_way : '0;
      rsp_data  <= (accept && any_hit) ?
                   data_q[l_idx][hit_way][l_off] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      if (fill_go) valid_q[f_idx][victim_sel] <= 1'b0;
      if (last_beat) valid_q[fill_idx_q][victim_q] <= 1'b1;
      if (flushing) valid_q[set_cnt_q] <= '0;
    end
  end

  // Tag and data contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (beat_en)
      data_q[fill_idx_q][victim_q][beat_cnt_q] <= fill_data;
    if (last_beat)
      tag_q[fill_idx_q][victim_q] <= fill_tag_q;
  end

  icache_plru #(
    .WAYS        (WAYS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_plru (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_index   (f_idx),
    .rd_victim  (plru_vic),
    .hit_en     (accept && any_hit),
    .hit_index  (l_idx),
    .hit_way    (hit_way),
    .fill_en    (last_beat),
    .fill_index (fill_idx_q),
    .fill_way   (victim_q),
    .clr_en     (flushing),
    .clr_index  (set_cnt_q)
  );

endmodule

// File: tb/tb_icache_storage_sa.sv
// Scoreboard bench for icache_storage_sa with an
// LRU-timestamp reference model.
module tb_icache_storage_sa;

  localparam int SETS = 32;
  localparam int WAYS = 2;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_addr = '0;
  logic        lookup_ready;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [31:0] rsp_data;
  logic [0:0]  rsp_way;
  logic        fill_start = 1'b0;
  logic [31:0] fill_addr = '0;
  logic        fill_ready;
  logic        fill_beat_valid = 1'b0;
  logic [31:0] fill_data = '0;
  logic        fill_done;
  logic        flush_req = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  icache_storage_sa dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .lookup_valid    (lookup_valid),
    .lookup_addr     (lookup_addr),
    .lookup_ready    (lookup_ready),
    .rsp_valid       (rsp_valid),
    .rsp_hit         (rsp_hit),
    .rsp_data        (rsp_data),
    .rsp_way         (rsp_way),
    .fill_start      (fill_start),
    .fill_addr       (fill_addr),
    .fill_ready      (fill_ready),
    .fill_beat_valid (fill_beat_valid),
    .fill_data       (fill_data),
    .fill_done       (fill_done),
    .flush_req       (flush_req),
    .busy            (busy)
  );

  typedef struct {
    bit          hit;
    logic [31:0] data;
    logic [0:0]  way;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: 0 idle, 1 fill, 2 flush.
  bit          m_valid [SETS][WAYS];
  logic [24:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][LW];
  longint      m_stamp [SETS][WAYS];
  longint      m_t;
  int          m_state, m_beat, m_set;
  int          m_fidx, m_fway;
  logic [24:0] m_ftag;
  bit          m_done;

  function automatic logic [31:0] mk(int tg, int idx, int off);
    logic [24:0] t;
    logic [4:0]  i;
    logic [1:0]  o;
    t = 25'(tg);
    i = 5'(idx);
    o = 2'(off);
    return {t, i, o};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_stamp[s][w] = 0;
      end
    m_state = 0;
    m_beat  = 0;
    m_set   = 0;
    m_done  = 0;
    m_t     = 1;
  endtask

  task automatic check_ctl();
    chk("lookup_ready", lookup_ready, m_state != 2);
    chk("fill_ready", fill_ready,
        m_state == 0 && !flush_req);
    chk("busy", busy, m_state != 0);
    chk("fill_done", fill_done, m_done);
  endtask

  // Effect of the coming rising edge on the model.
  task automatic model_step();
    bit   acc, hit, nd;
    int   wh, idx, off, fi, v;
    rsp_t r;
    acc = lookup_valid && (m_state != 2);
    hit = 0;
    wh  = 0;
    idx = int'(lookup_addr[6:2]);
    off = int'(lookup_addr[1:0]);
    if (acc) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (m_valid[idx][w] &&
            m_tag[idx][w] == lookup_addr[31:7]) begin
          hit = 1;
          wh  = w;
        end
      r.hit  = hit;
      r.data = hit ? m_data[idx][wh][off] : 32'h0;
      r.way  = hit ? 1'(wh) : 1'b0;
      exp_q.push_back(r);
    end
    nd = 0;
    case (m_state)
      0: begin
        if (flush_req) begin
          m_state = 2;
          m_set   = 0;
        end else if (fill_start) begin
          fi = int'(fill_addr[6:2]);
          v  = -1;
          for (int w = 0; w < WAYS; w++)
            if (!m_valid[fi][w] && v < 0) v = w;
          if (v < 0) begin
            v = 0;
            for (int w = 1; w < WAYS; w++)
              if (m_stamp[fi][w] < m_stamp[fi][v]) v = w;
          end
          m_valid[fi][v] = 0;
          m_fidx  = fi;
          m_fway  = v;
          m_ftag  = fill_addr[31:7];
          m_beat  = 0;
          m_state = 1;
        end
      end
      1: begin
        if (fill_beat_valid) begin
          m_data[m_fidx][m_fway][m_beat] = fill_data;
          if (m_beat == LW - 1) begin
            m_valid[m_fidx][m_fway] = 1;
            m_tag[m_fidx][m_fway]   = m_ftag;
            m_stamp[m_fidx][m_fway] = 2 * m_t + 1;
            nd      = 1;
            m_state = 0;
          end else begin
            m_beat++;
          end
        end
      end
      default: begin
        for (int w = 0; w < WAYS; w++) begin
          m_valid[m_set][w] = 0;
          m_stamp[m_set][w] = 0;
        end
        m_set++;
        if (m_set == SETS) m_state = 0;
      end
    endcase
    if (acc && hit) m_stamp[idx][wh] = 2 * m_t;
    m_done = nd;
    m_t++;
  endtask

  task automatic drive(bit lv, logic [31:0] la,
                       bit fs, logic [31:0] fa,
                       bit bv, logic [31:0] fd,
                       bit fl);
    @(negedge clk);
    lookup_valid    = lv;
    lookup_addr     = la;
    fill_start      = fs;
    fill_addr       = fa;
    fill_beat_valid = bv;
    fill_data       = fd;
    flush_req       = fl;
    #1;
    check_ctl();
    model_step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic look(logic [31:0] a);
    drive(1, a, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_line(logic [31:0] a, logic [31:0] base);
    drive(0, 0, 1, a, 0, 0, 0);
    for (int b = 0; b < LW; b++)
      drive(0, 0, 0, 0, 1, base + 32'(b), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    lookup_valid    = 0;
    fill_start      = 0;
    fill_beat_valid = 0;
    flush_req       = 0;
    reset_n         = 0;
    #1;
    model_reset();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_way", rsp_way, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lookup_ready", lookup_ready, 1);
    chk("rst_fill_ready", fill_ready, 1);
    @(negedge clk);
    reset_n = 1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return mk($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
  endfunction

  // Monitor: pops one expectation per presented response.
  initial begin
    rsp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 required none");
        end else begin
          r = exp_q.pop_front();
          chk("rsp_hit", rsp_hit, r.hit);
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_way", rsp_way, r.way);
        end
      end
    end
  end

  initial begin
    do_reset();
    look(32'h40);
    idle();
    fill_line(32'h40, 32'hA0);
    look(32'h42);
    idle();
    fill_line(mk(1, 0, 0), 32'h10);
    fill_line(mk(2, 0, 0), 32'h20);
    look(mk(1, 0, 0));
    fill_line(mk(3, 0, 0), 32'h30);
    look(mk(2, 0, 0));
    look(mk(1, 0, 3));
    look(mk(3, 0, 1));
    drive(1, mk(4, 0, 0), 1, mk(4, 0, 0), 0, 0, 0);
    for (int b = 0; b < LW; b++)
      drive(1, mk(4, 0, 2), 0, 0, 1, 32'h40 + 32'(b), 0);
    look(mk(4, 0, 2));
    idle();
    drive(0, 0, 1, mk(5, 1, 0), 0, 0, 1);
    for (int i = 0; i < 34; i++) idle();
    look(32'h41);
    look(mk(1, 0, 0));
    look(mk(4, 0, 0));
    idle();
    fill_line(mk(6, 2, 0), 32'h60);
    drive(0, 0, 1, mk(7, 2, 0), 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h70, 0);
    drive(0, 0, 0, 0, 1, 32'h71, 0);
    do_reset();
    look(mk(7, 2, 1));
    look(mk(6, 2, 1));
    idle();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0)
        do_reset();
      else
        drive($urandom_range(0, 9) < 7, rnd_addr(),
              $urandom_range(0, 9) == 0, rnd_addr(),
              $urandom_range(0, 9) < 6, $urandom,
              $urandom_range(0, 199) == 0);
    end
    idle();
    idle();
    idle();
    chk("pending_rsp", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
